// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Round-robin arbiter that shares one slave-side valid/ready bus between N
// master-side buses. The arbitration decision is taken in IDLE and registered
// into the grant register. The following GRANT cycle(s) forward the winner's
// request to the slave until it completes or the master withdraws. Every
// transfer therefore takes at least two cycles, and there is a mandatory IDLE
// cycle between grants.
//
// Ports
//   clk          clock
//   reset        synchronous active-high reset
//   m_valid      [N]     per-master request
//   m_ready      [N]     per-master completion pulse
//   m_address    [N*32]  master i at [32i+31:32i]
//   m_wstrobe    [N*4]   master i at [4i+3:4i], 0 means read
//   m_wdata      [N*32]  master i at [32i+31:32i]
//   m_rdata      [32]    slave read data, broadcast to all masters
//   m_irq        [1]     slave irq, broadcast to all masters
//   s_valid      [1]     slave request
//   s_ready      [1]     slave completion
//   s_address    [32]    forwarded address (0 in IDLE)
//   s_wstrobe    [4]     forwarded strobe  (0 in IDLE)
//   s_wdata      [32]    forwarded data    (0 in IDLE)
//   s_rdata      [32]    slave read data
//   s_irq        [1]     slave irq
//   grant_valid  [1]     high while in GRANT
//   grant_index  [IW]    current or most recent granted master
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    m_valid,
  output logic [N-1:0]    m_ready,
  input  logic [N*32-1:0] m_address,
  input  logic [N*4-1:0]  m_wstrobe,
  input  logic [N*32-1:0] m_wdata,
  output logic [31:0]     m_rdata,
  output logic            m_irq,
  output logic            s_valid,
  input  logic            s_ready,
  output logic [31:0]     s_address,
  output logic [3:0]      s_wstrobe,
  output logic [31:0]     s_wdata,
  input  logic [31:0]     s_rdata,
  input  logic            s_irq,
  output logic            grant_valid,
  output logic [IW-1:0]   grant_index
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // After reset the scan starts just past N-1, i.e. at master 0.
  localparam logic [IW-1:0] LAST_RST = IW'(N - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;

  logic [31:0]   addr_a  [N];
  logic [3:0]    strb_a  [N];
  logic [31:0]   wdata_a [N];

  logic          win_found_s;
  logic [IW-1:0] win_idx_s;
  logic          sel_valid_s;
  logic          in_grant_s;

  // Round-robin scan: first requester at from+1, from+2, ... modulo N.
  // Indices >= N are never produced, so non-power-of-2 N is safe.
  function automatic logic [IW:0] rr_pick(input logic [N-1:0]  req,
                                          input logic [IW-1:0] from);
    logic          found;
    logic [IW-1:0] pick;
    int            cand;
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(from) + k) % N;
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = IW'(cand);
      end else begin
        found = found;
      end
    end
    return {found, pick};
  endfunction

  // Split the flat master buses into per-master fields.
  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign addr_a[gi]  = m_address[gi*32 +: 32];
    assign strb_a[gi]  = m_wstrobe[gi*4 +: 4];
    assign wdata_a[gi] = m_wdata[gi*32 +: 32];
  end

  // Winner of the scan starting after the last completed master.
  always_comb begin
    {win_found_s, win_idx_s} = rr_pick(m_valid, last_q);
  end

  assign sel_valid_s = m_valid[grant_q];
  assign in_grant_s  = (state_q == ST_GRANT);

  // Next-state logic for the IDLE/GRANT controller.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          state_d = ST_GRANT;
          grant_d = win_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (sel_valid_s && s_ready) begin
          // Completed transfer: this master drops to lowest priority.
          last_d  = grant_q;
          state_d = ST_IDLE;
        end else if (!sel_valid_s) begin
          // Master withdrew without completion: abort, priority unchanged.
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GRANT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, grant and last-winner registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Slave-side request: reset in the same cycle suppresses the handshake so
  // an aborted transfer never produces a completion pulse.
  always_comb begin
    s_valid = 1'b0;
    if (in_grant_s && !reset) begin
      s_valid = sel_valid_s;
    end else begin
      s_valid = 1'b0;
    end
  end

  // Forwarded request fields, zero outside GRANT.
  always_comb begin
    s_address = 32'h0000_0000;
    s_wstrobe = 4'h0;
    s_wdata   = 32'h0000_0000;
    if (in_grant_s) begin
      s_address = addr_a[grant_q];
      s_wstrobe = strb_a[grant_q];
      s_wdata   = wdata_a[grant_q];
    end else begin
      s_address = 32'h0000_0000;
      s_wstrobe = 4'h0;
      s_wdata   = 32'h0000_0000;
    end
  end

  // Completion pulse goes only to the granted master.
  always_comb begin
    m_ready = '0;
    if (s_valid && s_ready) begin
      m_ready[grant_q] = 1'b1;
    end else begin
      m_ready = '0;
    end
  end

  assign grant_valid = in_grant_s;
  assign grant_index = grant_q;
  assign m_rdata     = s_rdata;
  assign m_irq       = s_irq;

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter with N=4. The stimulus process drives masters and
// slave and runs a transfer-level reference model, pushing the expected
// per-cycle outputs and expected completions into queues. A separate monitor
// pops and compares on every falling edge, and on every completion pulse.
module tb_bus_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    m_valid = '0;
  logic [N-1:0]    m_ready;
  logic [N*32-1:0] m_address = '0;
  logic [N*4-1:0]  m_wstrobe = '0;
  logic [N*32-1:0] m_wdata = '0;
  logic [31:0]     m_rdata;
  logic            m_irq;
  logic            s_valid;
  logic            s_ready = 1'b0;
  logic [31:0]     s_address;
  logic [3:0]      s_wstrobe;
  logic [31:0]     s_wdata;
  logic [31:0]     s_rdata = 32'h0;
  logic            s_irq = 1'b0;
  logic            grant_valid;
  logic [IW-1:0]   grant_index;

  bus_arbiter #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_address(m_address), .m_wstrobe(m_wstrobe), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_irq(m_irq),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_address(s_address), .s_wstrobe(s_wstrobe), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_irq(s_irq),
    .grant_valid(grant_valid), .grant_index(grant_index)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          sv;
    logic [N-1:0]  mr;
    logic          gv;
    logic [IW-1:0] gi;
    logic [31:0]   addr;
    logic [3:0]    strb;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          irq;
  } cyc_t;

  typedef struct packed {
    logic [31:0] m;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } cmp_t;

  cyc_t cyc_q[$];
  cmp_t cmp_q[$];

  int checks   = 0;
  int failures = 0;

  // Master-side pending transactions owned by the bench.
  bit   [N-1:0] pend      = '0;
  bit   [N-1:0] done_prev = '0;
  bit   [N-1:0] auto_mask = '0;
  logic [31:0]  t_addr [N];
  logic [3:0]   t_strb [N];
  logic [31:0]  t_wdata[N];

  // Reference model: is a master holding the bus, which one, who went last.
  bit model_busy  = 1'b0;
  int model_cur   = 0;
  int model_last  = N - 1;
  bit model_known = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic int rr_next(input bit [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic set_txn(input int i, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d);
    pend[i]    = 1'b1;
    t_addr[i]  = a;
    t_strb[i]  = s;
    t_wdata[i] = d;
  endtask

  // Start of a cycle: retire last cycle's completions, resubmit auto masters.
  task automatic cycle_begin();
    @(posedge clk);
    #1;
    pend      = pend & ~done_prev;
    done_prev = '0;
    reset     = 1'b0;
    s_rdata   = $urandom;
    for (int i = 0; i < N; i++) begin
      if (auto_mask[i] && !pend[i])
        set_txn(i, 32'(16 * (i + 1)), 4'hF, 32'(32'h1111_1111 * (i + 1)));
    end
  endtask

  // End of stimulus for a cycle: drive pins, predict, advance the model.
  task automatic cycle_end();
    cyc_t e;
    int   w;
    s_irq   = 1'($urandom);
    m_valid = pend;
    for (int i = 0; i < N; i++) begin
      m_address[i*32 +: 32] = t_addr[i];
      m_wstrobe[i*4 +: 4]   = t_strb[i];
      m_wdata[i*32 +: 32]   = t_wdata[i];
    end
    e.gv    = model_busy;
    e.gi    = IW'(model_cur);
    e.sv    = model_busy && pend[model_cur] && !reset;
    e.mr    = (e.sv && s_ready) ? N'(1 << model_cur) : '0;
    e.addr  = model_busy ? t_addr[model_cur]  : 32'h0;
    e.strb  = model_busy ? t_strb[model_cur]  : 4'h0;
    e.wdata = model_busy ? t_wdata[model_cur] : 32'h0;
    e.rdata = s_rdata;
    e.irq   = s_irq;
    if (model_known) cyc_q.push_back(e);
    if (e.mr != '0) begin
      cmp_q.push_back({32'(model_cur), t_addr[model_cur], t_strb[model_cur],
                       t_wdata[model_cur], s_rdata});
      done_prev[model_cur] = 1'b1;
    end
    if (reset) begin
      model_busy  = 1'b0;
      model_cur   = 0;
      model_last  = N - 1;
      model_known = 1'b1;
    end else if (!model_busy) begin
      w = rr_next(pend, model_last);
      if (w >= 0) begin
        model_busy = 1'b1;
        model_cur  = w;
      end
    end else if (e.mr != '0) begin
      model_last = model_cur;
      model_busy = 1'b0;
    end else if (!pend[model_cur]) begin
      model_busy = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      cycle_begin();
      reset = 1'b1;
      cycle_end();
    end
  endtask

  task automatic drain();
    auto_mask = '0;
    for (int i = 0; i < 40; i++) begin
      cycle_begin();
      s_ready = 1'b1;
      cycle_end();
      if (pend == done_prev && !model_busy) break;
    end
    chk("drain_timeout", {31'h0, (pend != done_prev) || model_busy}, 32'h0);
  endtask

  // Monitor: compare the DUT against the queued expectations.
  initial begin
    cyc_t e;
    cmp_t c;
    int   idx;
    forever begin
      @(negedge clk);
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        chk("s_valid",     {31'h0, s_valid},     {31'h0, e.sv});
        chk("m_ready",     32'(m_ready),         32'(e.mr));
        chk("grant_valid", {31'h0, grant_valid}, {31'h0, e.gv});
        chk("grant_index", 32'(grant_index),     32'(e.gi));
        chk("s_address",   s_address,            e.addr);
        chk("s_wstrobe",   32'(s_wstrobe),       32'(e.strb));
        chk("s_wdata",     s_wdata,              e.wdata);
        chk("m_rdata",     m_rdata,              e.rdata);
        chk("m_irq",       {31'h0, m_irq},       {31'h0, e.irq});
        if (m_ready != '0) begin
          if (cmp_q.size() == 0) begin
            chk("unexpected_completion", 32'(m_ready), 32'h0);
          end else begin
            c   = cmp_q.pop_front();
            idx = -1;
            for (int i = N - 1; i >= 0; i--) if (m_ready[i]) idx = i;
            chk("xfer_master", 32'(idx), c.m);
            chk("xfer_addr",   s_address, c.addr);
            chk("xfer_strb",   32'(s_wstrobe), 32'(c.strb));
            chk("xfer_wdata",  s_wdata, c.wdata);
            chk("xfer_rdata",  m_rdata, c.rdata);
          end
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by a randomized run.
  initial begin
    for (int i = 0; i < N; i++) set_txn(i, 32'h0, 4'h0, 32'h0);
    pend = '0;

    // Reset, then stay idle.
    do_reset(2);
    for (int i = 0; i < 10; i++) begin
      cycle_begin();
      s_ready = 1'b0;
      cycle_end();
    end

    // Single read with a zero-wait slave.
    cycle_begin();
    set_txn(0, 32'h0000_0100, 4'h0, 32'h0);
    s_ready = 1'b1;
    s_rdata = 32'hDEAD_BEEF;
    cycle_end();
    cycle_begin();
    s_ready = 1'b1;
    s_rdata = 32'hDEAD_BEEF;
    cycle_end();
    drain();

    // Two-master contention from reset: grants alternate 0,1,0,1.
    do_reset(1);
    auto_mask = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      cycle_begin();
      s_ready = 1'b1;
      cycle_end();
    end
    drain();

    // Wait states: m1 held for 3 cycles while m0 waits.
    cycle_begin();
    set_txn(1, 32'h0000_0040, 4'h3, 32'hCAFE_0001);
    s_ready = 1'b0;
    cycle_end();
    cycle_begin();
    set_txn(0, 32'h0000_0080, 4'hF, 32'h0BAD_F00D);
    s_ready = 1'b0;
    cycle_end();
    for (int i = 0; i < 2; i++) begin
      cycle_begin();
      s_ready = 1'b0;
      cycle_end();
    end
    cycle_begin();
    s_ready = 1'b1;
    cycle_end();
    cycle_begin();
    s_ready = 1'b0;
    cycle_end();
    drain();

    // Abort: granted master withdraws; priority must not move.
    cycle_begin();
    set_txn(1, 32'h0000_0200, 4'h1, 32'h5555_AAAA);
    s_ready = 1'b0;
    cycle_end();
    cycle_begin();
    s_ready = 1'b0;
    cycle_end();
    cycle_begin();
    pend[1] = 1'b0;
    s_ready = 1'b0;
    cycle_end();
    cycle_begin();
    set_txn(0, 32'h0000_0300, 4'h0, 32'h0);
    set_txn(1, 32'h0000_0304, 4'h0, 32'h0);
    s_ready = 1'b0;
    cycle_end();
    drain();

    // Reset during m2's grant with s_ready high, then all four contend.
    cycle_begin();
    set_txn(2, 32'h0000_0400, 4'hF, 32'h7777_0000);
    s_ready = 1'b0;
    cycle_end();
    cycle_begin();
    s_ready = 1'b0;
    cycle_end();
    cycle_begin();
    reset   = 1'b1;
    s_ready = 1'b1;
    cycle_end();
    auto_mask = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      cycle_begin();
      s_ready = 1'b1;
      cycle_end();
    end
    drain();

    // Randomized traffic with occasional withdrawals and resets.
    for (int c = 0; c < 3000; c++) begin
      cycle_begin();
      reset = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && !done_prev[i]) begin
          if ($urandom_range(0, 9) < 3)
            set_txn(i, $urandom, 4'($urandom), $urandom);
        end else if (pend[i] && $urandom_range(0, 99) == 0) begin
          pend[i] = 1'b0;
        end
      end
      s_ready = 1'($urandom);
      cycle_end();
    end
    drain();

    @(posedge clk);
    @(posedge clk);
    chk("leftover_cycles",      32'(cyc_q.size()), 32'h0);
    chk("leftover_completions", 32'(cmp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
